// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
// Contents:
//   fetch_state_t  - fetch FSM state encoding
//   OP_W           - width of the op field at the top of each instruction
//   OP_*           - opcode constants, matching the control decode table
package instruction_fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_SQUASH = 2'd2,
        S_HOLD   = 2'd3
    } fetch_state_t;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
    localparam logic [OP_W-1:0] OP_GRT  = 4'b0001;
    localparam logic [OP_W-1:0] OP_SUB  = 4'b0010;
    localparam logic [OP_W-1:0] OP_EQ   = 4'b0011;
    localparam logic [OP_W-1:0] OP_JALR = 4'b0100;
    localparam logic [OP_W-1:0] OP_LUI  = 4'b0101;
    localparam logic [OP_W-1:0] OP_JAL  = 4'b0110;
    localparam logic [OP_W-1:0] OP_ADDI = 4'b1000;
    localparam logic [OP_W-1:0] OP_LW   = 4'b1001;
    localparam logic [OP_W-1:0] OP_SW   = 4'b1010;
    localparam logic [OP_W-1:0] OP_BNE  = 4'b1011;
    localparam logic [OP_W-1:0] OP_WRI  = 4'b1100;

endpackage

// File: rtl/instruction_fetch_unit_skid.sv
// One-entry holding register for an instruction and the address it came from.
// Catches a memory response that lands while the output slot is full and stalled.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   load              - capture in_instr/in_pc, mark full
//   unload            - entry handed to the output slot, mark empty
//   flush             - discard entry (redirect); wins over load/unload
//   in_instr, in_pc   - data to capture
//   valid, instr, pc  - current contents
module fetch_skid_reg #(
    parameter int PC_W    = 16,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               unload,
    input  logic               flush,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc
);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= in_instr;
            pc    <= in_pc;
        end else if (unload) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, fetches instructions over a req/ack memory port and
// presents at most one instruction per cycle to decode.
// Ports:
//   clk, reset                   - clock, synchronous active-high reset
//   imem_req, imem_addr          - fetch request and its address
//   imem_ack, imem_rdata         - response strobe and instruction data
//   stall                        - decode is not taking the output slot
//   redirect_valid, redirect_pc  - control-flow redirect, flushes the stage
//   if_valid, if_instr, if_op, if_pc - output slot to decode/control
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [OP_W-1:0]    if_op,
    output logic [PC_W-1:0]    if_pc
);

    localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

    fetch_state_t      state, state_next;
    logic [PC_W-1:0]   pc, pc_next, addr_next, addr_inc;
    logic              deliver, to_skid, from_skid, flush;
    logic              skid_valid;
    logic [INSTR_W-1:0] skid_instr;
    logic [PC_W-1:0]   skid_pc;

    // Wraps naturally modulo 2^PC_W.
    assign addr_inc = imem_addr + STEP;
    assign imem_req = (state == S_FETCH) || (state == S_SQUASH);
    assign if_op    = if_instr[INSTR_W-1 -: OP_W];

    fetch_skid_reg #(.PC_W(PC_W), .INSTR_W(INSTR_W)) u_skid (
        .clk      (clk),
        .reset    (reset),
        .load     (to_skid),
        .unload   (from_skid),
        .flush    (flush),
        .in_instr (imem_rdata),
        .in_pc    (imem_addr),
        .valid    (skid_valid),
        .instr    (skid_instr),
        .pc       (skid_pc)
    );

    // A request already on the bus cannot be withdrawn, so a redirect without a
    // same-cycle ack parks in S_SQUASH until that response arrives and is dropped.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        addr_next  = imem_addr;
        deliver    = 1'b0;
        to_skid    = 1'b0;
        from_skid  = 1'b0;
        flush      = 1'b0;
        if (redirect_valid) begin
            flush   = 1'b1;
            pc_next = redirect_pc;
            if ((state == S_FETCH || state == S_SQUASH) && !imem_ack) begin
                state_next = S_SQUASH;
            end else begin
                state_next = S_FETCH;
                addr_next  = redirect_pc;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    state_next = S_FETCH;
                    addr_next  = pc;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        pc_next   = addr_inc;
                        addr_next = addr_inc;
                        if (if_valid && stall) begin
                            to_skid    = 1'b1;
                            state_next = S_HOLD;
                        end else begin
                            deliver = 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (!if_valid || !stall) begin
                        from_skid  = skid_valid;
                        state_next = S_FETCH;
                    end
                end
                S_SQUASH: begin
                    if (imem_ack) begin
                        state_next = S_FETCH;
                        addr_next  = pc;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // FSM, PC and request address registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            imem_addr <= '0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            imem_addr <= addr_next;
        end
    end

    // Output slot: holds while stalled, drains when consumed with nothing new behind it.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc    <= '0;
        end else if (flush) begin
            if_valid <= 1'b0;
        end else if (deliver) begin
            if_valid <= 1'b1;
            if_instr <= imem_rdata;
            if_pc    <= imem_addr;
        end else if (from_skid) begin
            if_valid <= 1'b1;
            if_instr <= skid_instr;
            if_pc    <= skid_pc;
        end else if (if_valid && !stall) begin
            if_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit. A second instance with
// RESET_PC=0xFFFE shares all inputs and exercises PC wraparound.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;

    logic        imem_req, if_valid;
    logic [15:0] imem_addr, if_instr, if_pc;
    logic [3:0]  if_op;

    logic        w_imem_req, w_if_valid;
    logic [15:0] w_imem_addr, w_if_instr, w_if_pc;
    logic [3:0]  w_if_op;

    int testCount = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_instr(if_instr), .if_op(if_op), .if_pc(if_pc)
    );

    instruction_fetch_unit #(.RESET_PC(16'hFFFE)) dutWrap (
        .clk(clk), .reset(reset), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(w_if_valid), .if_instr(w_if_instr), .if_op(w_if_op), .if_pc(w_if_pc)
    );

    // Drives inputs, then advances one clock and settles 1 time unit past the edge.
    task automatic applyStimulus(input logic rst, input logic ack, input logic [15:0] rdata,
                                 input logic stl, input logic rv, input logic [15:0] rpc);
        reset          = rst;
        imem_ack       = ack;
        imem_rdata     = rdata;
        stall          = stl;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        // ---- reset state ----
        applyStimulus(1, 0, 16'h8123, 0, 0, 16'h0);
        applyStimulus(1, 0, 16'h8123, 0, 0, 16'h0);
        checkOutput("rst_req",    32'(imem_req),  32'd0);
        checkOutput("rst_addr",   32'(imem_addr), 32'h0);
        checkOutput("rst_valid",  32'(if_valid),  32'd0);
        checkOutput("rst_instr",  32'(if_instr),  32'h0);
        checkOutput("rst_op",     32'(if_op),     32'h0);
        checkOutput("rst_pc",     32'(if_pc),     32'h0);
        checkOutput("rst_w_addr", 32'(w_imem_addr), 32'h0);

        // ---- test 1 / 5: ack tied high, streaming fetch + wraparound ----
        applyStimulus(0, 1, 16'h8123, 0, 0, 16'h0);
        checkOutput("t1_idle_req",  32'(imem_req),    32'd1);
        checkOutput("t1_addr0",     32'(imem_addr),   32'h0000);
        checkOutput("t1_novalid",   32'(if_valid),    32'd0);
        checkOutput("t5_addr0",     32'(w_imem_addr), 32'hFFFE);
        applyStimulus(0, 1, 16'h8123, 0, 0, 16'h0);
        checkOutput("t1_addr1",     32'(imem_addr),   32'h0002);
        checkOutput("t1_valid",     32'(if_valid),    32'd1);
        checkOutput("t1_op",        32'(if_op),       32'h8);
        checkOutput("t1_instr",     32'(if_instr),    32'h8123);
        checkOutput("t1_pc",        32'(if_pc),       32'h0000);
        checkOutput("t5_addr1",     32'(w_imem_addr), 32'h0000);
        checkOutput("t5_pc",        32'(w_if_pc),     32'hFFFE);
        applyStimulus(0, 1, 16'h8123, 0, 0, 16'h0);
        checkOutput("t1_addr2",     32'(imem_addr),   32'h0004);
        checkOutput("t1_pc2",       32'(if_pc),       32'h0002);
        checkOutput("t5_addr2",     32'(w_imem_addr), 32'h0002);

        // ---- test 2: stall with skid ----
        applyStimulus(1, 0, 16'h0, 0, 0, 16'h0);
        applyStimulus(0, 1, 16'hA000, 0, 0, 16'h0);
        applyStimulus(0, 1, 16'hA000, 0, 0, 16'h0);
        checkOutput("t2_first_pc", 32'(if_pc), 32'h0000);
        applyStimulus(0, 1, 16'hA002, 1, 0, 16'h0);
        checkOutput("t2_hold_req",   32'(imem_req), 32'd0);
        checkOutput("t2_hold_pc",    32'(if_pc),    32'h0000);
        checkOutput("t2_hold_instr", 32'(if_instr), 32'hA000);
        checkOutput("t2_hold_valid", 32'(if_valid), 32'd1);
        applyStimulus(0, 1, 16'hDEAD, 1, 0, 16'h0);
        checkOutput("t2_hold2_req", 32'(imem_req), 32'd0);
        checkOutput("t2_hold2_pc",  32'(if_pc),    32'h0000);
        applyStimulus(0, 1, 16'hDEAD, 1, 0, 16'h0);
        checkOutput("t2_hold3_pc",  32'(if_pc),    32'h0000);
        applyStimulus(0, 1, 16'hDEAD, 0, 0, 16'h0);
        checkOutput("t2_skid_pc",    32'(if_pc),     32'h0002);
        checkOutput("t2_skid_instr", 32'(if_instr),  32'hA002);
        checkOutput("t2_skid_valid", 32'(if_valid),  32'd1);
        checkOutput("t2_resume_req", 32'(imem_req),  32'd1);
        checkOutput("t2_resume_addr",32'(imem_addr), 32'h0004);
        applyStimulus(0, 1, 16'hA004, 0, 0, 16'h0);
        checkOutput("t2_third_pc",    32'(if_pc),    32'h0004);
        checkOutput("t2_third_instr", 32'(if_instr), 32'hA004);

        // ---- test 3: redirect while waiting for a slow ack ----
        applyStimulus(1, 0, 16'h0, 0, 0, 16'h0);
        applyStimulus(0, 0, 16'h0, 0, 0, 16'h0);
        checkOutput("t3_req",  32'(imem_req),  32'd1);
        checkOutput("t3_addr", 32'(imem_addr), 32'h0000);
        applyStimulus(0, 0, 16'h0, 0, 1, 16'h0040);
        checkOutput("t3_sq_addr",  32'(imem_addr), 32'h0000);
        checkOutput("t3_sq_req",   32'(imem_req),  32'd1);
        applyStimulus(0, 0, 16'h0, 0, 0, 16'h0);
        checkOutput("t3_sq2_addr", 32'(imem_addr), 32'h0000);
        applyStimulus(0, 1, 16'hBEEF, 0, 0, 16'h0);
        checkOutput("t3_drop_valid", 32'(if_valid),  32'd0);
        checkOutput("t3_new_addr",   32'(imem_addr), 32'h0040);
        checkOutput("t3_new_req",    32'(imem_req),  32'd1);
        applyStimulus(0, 1, 16'h4444, 0, 0, 16'h0);
        checkOutput("t3_valid", 32'(if_valid), 32'd1);
        checkOutput("t3_pc",    32'(if_pc),    32'h0040);
        checkOutput("t3_op",    32'(if_op),    32'h4);

        // ---- test 4: redirect + ack + stall with full slot ----
        applyStimulus(0, 1, 16'h9999, 1, 1, 16'h0100);
        checkOutput("t4_valid", 32'(if_valid),  32'd0);
        checkOutput("t4_addr",  32'(imem_addr), 32'h0100);
        applyStimulus(0, 1, 16'h5555, 0, 0, 16'h0);
        checkOutput("t4_next_pc",    32'(if_pc),    32'h0100);
        checkOutput("t4_next_instr", 32'(if_instr), 32'h5555);
        checkOutput("t4_next_addr",  32'(imem_addr),32'h0102);

        // ---- test 6: reset with request outstanding, late ack ignored ----
        applyStimulus(0, 0, 16'h0, 0, 0, 16'h0);
        applyStimulus(1, 0, 16'h0, 0, 0, 16'h0);
        checkOutput("t6_req",   32'(imem_req),  32'd0);
        checkOutput("t6_valid", 32'(if_valid),  32'd0);
        checkOutput("t6_addr",  32'(imem_addr), 32'h0000);
        applyStimulus(0, 1, 16'h7777, 0, 0, 16'h0);
        checkOutput("t6_idle_addr",  32'(imem_addr), 32'h0000);
        checkOutput("t6_idle_valid", 32'(if_valid),  32'd0);
        applyStimulus(0, 0, 16'h0, 0, 0, 16'h0);
        checkOutput("t6_late_valid", 32'(if_valid),  32'd0);
        checkOutput("t6_late_addr",  32'(imem_addr), 32'h0000);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
